mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, data and address width; TIMEOUT, default 15, maximum wait cycles per memory access.
REQ-002 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 if_req  in  1  fetch request (level); if_addr  in  WIDTH  fetch address.
REQ-005 if_rdata  out  WIDTH  fetched word; if_valid  out  1  one-cycle fetch-complete pulse.
REQ-006 flush_F  in  1  discard any in-flight or completing fetch.
REQ-007 dm_req  in  1  data request (level); dm_we  in  1  write enable; dm_size  in  3  one-hot {word, half, byte}; dm_addr  in  WIDTH; dm_wdata  in  WIDTH.
REQ-008 dm_rdata  out  WIDTH  load data; dm_valid  out  1  one-cycle data-complete pulse.
REQ-009 mem_req  out  1; mem_we  out  1; mem_size  out  3; mem_addr  out  WIDTH; mem_wdata  out  WIDTH; mem_rdata  in  WIDTH; mem_ready  in  1: single shared memory port.
REQ-010 stall_F  out  1  freeze PC and fetch/decode register; stall_M  out  1  freeze all stages up to memory.
REQ-011 timeout_err  out  1  sticky error flag.

Function
REQ-012 FSM states SHALL be IDLE, I_WAIT, D_WAIT.
REQ-013 IDLE: dm_req=1 -> D_WAIT; else if_req=1 -> I_WAIT; else IDLE. Data SHALL have priority over fetch.
REQ-014 On grant, address, we, size and wdata SHALL be latched; mem_* outputs SHALL be driven from the latched values and be stable for the whole wait state.
REQ-015 mem_req SHALL be 1 exactly while in I_WAIT or D_WAIT; mem_we SHALL be 0 in I_WAIT; mem_size SHALL be word (100) in I_WAIT.
REQ-016 Completion: mem_ready=1 in a wait state -> at that edge, mem_rdata captured into if_rdata (I_WAIT) or dm_rdata (D_WAIT), matching valid asserted for exactly the next cycle, state -> IDLE.
REQ-017 Minimum access latency SHALL be 2 cycles, grant edge to valid cycle (mem_ready=1 in the first wait cycle).
REQ-018 In IDLE, a request whose own valid is asserted in that cycle SHALL be ignored for arbitration; the other requester MAY be granted.
REQ-019 if_rdata and dm_rdata SHALL hold their last value until the next completion of the same requester.
REQ-020 Wait counter: cleared on grant; +1 per wait cycle with mem_ready=0; on reaching TIMEOUT -> mem_req drops, timeout_err set (sticky until reset), matching valid pulsed with rdata=0, state -> IDLE.
REQ-021 Flush: flush_F=1 during I_WAIT sets a drop flag; at completion with drop flag set, or with flush_F=1 in the completion cycle, if_valid SHALL stay 0 and if_rdata SHALL NOT update; drop flag cleared on leaving I_WAIT.
REQ-022 flush_F SHALL NOT affect D_WAIT, dm_valid or arbitration in IDLE.
REQ-023 stall_M = dm_req AND NOT dm_valid (combinational).
REQ-024 stall_F = (if_req AND NOT if_valid) OR stall_M (combinational).
REQ-025 A store (dm_we=1) SHALL complete identically to a load; dm_rdata captures mem_rdata regardless.

Reset
REQ-026 rst=0 SHALL immediately force: state IDLE, counter 0, drop flag 0, timeout_err 0, all mem_* outputs 0, if_valid=dm_valid=0, if_rdata=dm_rdata=0, independent of clk.
REQ-027 Reset mid-access SHALL abandon the access; no valid pulse SHALL follow release of reset.

Verification
REQ-028 Fetch only: if_req=1, if_addr=0x00000010, mem_ready=1 after 2 wait cycles, mem_rdata=0x00A00513 -> mem_addr=0x10 throughout, if_valid one cycle, if_rdata=0x00A00513, stall_F=1 until valid.
REQ-029 Simultaneous if_req and dm_req (load 0x100, size=word) -> D_WAIT first, dm_valid, then I_WAIT granted; stall_F=1 across both.
REQ-030 Flush: flush_F=1 in second I_WAIT cycle, mem_ready=1 in fourth -> if_valid never asserted, if_rdata unchanged, state IDLE.
REQ-031 Timeout: D_WAIT, mem_ready held 0 -> after 15 wait cycles mem_req=0, dm_valid=1, dm_rdata=0, timeout_err=1 held until rst.
REQ-032 Store then reset: dm_we=1, dm_wdata=0xDEADBEEF, size=byte, rst=0 in first wait cycle -> mem_req=0 immediately, no dm_valid after release.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Single shared memory port between the arbiter (master) and the memory (slave).
// The memory answers a held request with mem_ready and mem_rdata.
interface mem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             mem_req;
    logic             mem_we;
    logic [2:0]       mem_size;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;

    modport master (
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port. Data wins ties.
// Each access has a bounded wait; an expired access returns zero and raises a sticky error.
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_valid,
    input  logic             flush_F,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [2:0]       dm_size,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_valid,
    mem_arbiter_if.master    mem,
    output logic             stall_F,
    output logic             stall_M,
    output logic             timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [2:0]       size_q, size_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic             if_valid_q, if_valid_d;
    logic             dm_valid_q, dm_valid_d;

    logic d_ok, i_ok, timed_out, done, busy;

    // A requester still seeing its own completion pulse is not asking for a new access.
    assign d_ok      = dm_req & ~dm_valid_q;
    assign i_ok      = if_req & ~if_valid_q;
    assign timed_out = ~mem.mem_ready & (cnt_q == CW'(TIMEOUT - 1));
    assign done      = mem.mem_ready | timed_out;

    always_comb begin
        // NOTE: every variable gets its default first, so no path through the case leaves one unassigned and infers a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        size_d     = size_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                drop_d = 1'b0;
                if (d_ok) begin
                    state_d = D_WAIT;
                    addr_d  = dm_addr;
                    wdata_d = dm_wdata;
                    we_d    = dm_we;
                    size_d  = dm_size;
                end else if (i_ok) begin
                    state_d = I_WAIT;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    we_d    = 1'b0;
                    size_d  = 3'b100;
                end
            end

            I_WAIT: begin
                if (flush_F) drop_d = 1'b1;
                if (done) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    err_d   = err_q | timed_out;
                    // A fetch flushed at any point of its wait, including the last cycle, never returns.
                    if (!(drop_q || flush_F)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem.mem_ready ? mem.mem_rdata : '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            D_WAIT: begin
                if (done) begin
                    state_d    = IDLE;
                    err_d      = err_q | timed_out;
                    dm_valid_d = 1'b1;
                    dm_rdata_d = mem.mem_ready ? mem.mem_rdata : '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: read-data registers are reset along with control, since their value is visible to the pipeline from the first cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= 3'b000;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            size_q     <= size_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign mem.mem_req   = busy;
    assign mem.mem_we    = busy & we_q;
    assign mem.mem_size  = busy ? size_q : 3'b000;
    assign mem.mem_addr  = busy ? addr_q : '0;
    assign mem.mem_wdata = busy ? wdata_q : '0;

    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign if_valid    = if_valid_q;
    assign dm_valid    = dm_valid_q;
    assign timeout_err = err_q;
    assign stall_M     = dm_req & ~dm_valid_q;
    assign stall_F     = (if_req & ~if_valid_q) | stall_M;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a memory model answers each access after a chosen delay,
// expected completions are queued at issue and popped by an independent monitor.
module tb_mem_arbiter;
    localparam int WIDTH = 32;
    localparam int TO    = 15;

    typedef struct {
        bit          do_i;
        bit          do_d;
        logic [31:0] i_addr;
        logic [31:0] i_data;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] d_data;
        logic        d_we;
        logic [2:0]  d_size;
        int          i_delay;
        int          d_delay;
        int          i_flush;
        int          d_offset;
    } scen_t;

    typedef struct {
        bit          fetch;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        we;
        logic [2:0]  size;
        int          delay;
        int          flush;
    } acc_t;

    typedef struct {
        logic [31:0] data;
        bit          to;
    } rsp_t;

    logic             clk;
    logic             rst;
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic [WIDTH-1:0] if_rdata;
    logic             if_valid;
    logic             flush_F;
    logic             dm_req;
    logic             dm_we;
    logic [2:0]       dm_size;
    logic [WIDTH-1:0] dm_addr;
    logic [WIDTH-1:0] dm_wdata;
    logic [WIDTH-1:0] dm_rdata;
    logic             dm_valid;
    logic             stall_F;
    logic             stall_M;
    logic             timeout_err;

    mem_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mem_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .flush_F(flush_F),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
        .mem(bus),
        .stall_F(stall_F), .stall_M(stall_M), .timeout_err(timeout_err)
    );

    acc_t acc_q[$];
    rsp_t if_exp_q[$];
    rsp_t dm_exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expected completion whenever a valid pulse appears.
    initial begin : monitor
        logic [31:0] last_i;
        logic [31:0] last_d;
        bit          exp_err;
        rsp_t        r;
        last_i  = '0;
        last_d  = '0;
        exp_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                last_i  = '0;
                last_d  = '0;
                exp_err = 1'b0;
                check("reset mem_req", bus.mem_req, 0);
                check("reset mem_we", bus.mem_we, 0);
                check("reset mem_size", bus.mem_size, 0);
                check("reset mem_addr", bus.mem_addr, 0);
                check("reset mem_wdata", bus.mem_wdata, 0);
                check("reset valids", {if_valid, dm_valid}, 0);
                check("reset if_rdata", if_rdata, 0);
                check("reset dm_rdata", dm_rdata, 0);
                check("reset timeout_err", timeout_err, 0);
            end else begin
                if (if_valid) begin
                    check("if_valid expected", if_exp_q.size() > 0, 1);
                    if (if_exp_q.size() > 0) begin
                        r      = if_exp_q.pop_front();
                        last_i = r.data;
                        if (r.to) exp_err = 1'b1;
                    end
                end
                if (dm_valid) begin
                    check("dm_valid expected", dm_exp_q.size() > 0, 1);
                    if (dm_exp_q.size() > 0) begin
                        r      = dm_exp_q.pop_front();
                        last_d = r.data;
                        if (r.to) exp_err = 1'b1;
                    end
                end
                check("if_rdata", if_rdata, last_i);
                check("dm_rdata", dm_rdata, last_d);
                check("timeout_err", timeout_err, exp_err);
            end
            check("stall_M", stall_M, dm_req && !dm_valid);
            check("stall_F", stall_F, (if_req && !if_valid) || (dm_req && !dm_valid));
        end
    end

    function automatic int pick_delay();
        int k;
        k = int'($urandom_range(0, 15));
        return (k == 15) ? 99 : k % 6;
    endfunction

    function automatic scen_t rand_scen();
        scen_t s;
        int    k;
        k          = int'($urandom_range(0, 2));
        s.do_i     = (k != 1);
        s.do_d     = (k != 0);
        s.i_addr   = $urandom & 32'hFFFF_FFFC;
        s.i_data   = $urandom;
        s.d_addr   = $urandom;
        s.d_wdata  = $urandom;
        s.d_data   = $urandom;
        s.d_we     = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
            0:       s.d_size = 3'b100;
            1:       s.d_size = 3'b010;
            default: s.d_size = 3'b001;
        endcase
        s.i_delay = pick_delay();
        s.d_delay = pick_delay();
        s.i_flush = -1;
        if (s.i_delay < TO && $urandom_range(0, 3) == 0)
            s.i_flush = int'($urandom_range(0, s.i_delay));
        s.d_offset = (s.do_i && s.do_d) ? int'($urandom_range(0, 3)) : 0;
        return s;
    endfunction

    task automatic raise_dm(input scen_t s);
        dm_req   = 1'b1;
        dm_we    = s.d_we;
        dm_size  = s.d_size;
        dm_addr  = s.d_addr;
        dm_wdata = s.d_wdata;
    endtask

    task automatic run_scen(input scen_t s);
        acc_t a_i, a_d, cur;
        bit   i_done, d_done, d_started, i_rel, d_rel, in_acc;
        int   idx, lim, t;
        a_i = '{fetch: 1'b1, addr: s.i_addr, wdata: 32'h0, data: s.i_data, we: 1'b0,
                size: 3'b100, delay: s.i_delay, flush: s.i_flush};
        a_d = '{fetch: 1'b0, addr: s.d_addr, wdata: s.d_wdata, data: s.d_data, we: s.d_we,
                size: s.d_size, delay: s.d_delay, flush: -1};
        // Data wins a simultaneous request; a later data request waits behind the fetch.
        if (s.do_d && (!s.do_i || s.d_offset == 0)) begin
            acc_q.push_back(a_d);
            if (s.do_i) acc_q.push_back(a_i);
        end else begin
            if (s.do_i) acc_q.push_back(a_i);
            if (s.do_d) acc_q.push_back(a_d);
        end
        if (s.do_i && s.i_flush < 0)
            if_exp_q.push_back('{data: (s.i_delay >= TO) ? 32'h0 : s.i_data, to: s.i_delay >= TO});
        if (s.do_d)
            dm_exp_q.push_back('{data: (s.d_delay >= TO) ? 32'h0 : s.d_data, to: s.d_delay >= TO});

        if_req    = s.do_i;
        if_addr   = s.i_addr;
        d_started = !s.do_d;
        if (s.do_d && s.d_offset == 0) begin
            raise_dm(s);
            d_started = 1'b1;
        end
        i_done = !s.do_i;
        d_done = !s.do_d;
        i_rel  = 1'b0;
        d_rel  = 1'b0;
        in_acc = 1'b0;
        idx    = 0;
        cur    = a_d;

        for (t = 1; t <= 80; t++) begin
            @(posedge clk); #1;
            // Requesters hold their request through the valid cycle, then drop it.
            if (i_rel) begin
                if_req = 1'b0; i_done = 1'b1; i_rel = 1'b0;
            end else if (if_req && if_valid) i_rel = 1'b1;
            if (d_rel) begin
                dm_req = 1'b0; d_done = 1'b1; d_rel = 1'b0;
            end else if (dm_req && dm_valid) d_rel = 1'b1;
            if (!d_started && t >= s.d_offset) begin
                raise_dm(s);
                d_started = 1'b1;
            end

            if (bus.mem_req) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    idx    = 0;
                    check("grant expected", acc_q.size() > 0, 1);
                    if (acc_q.size() > 0) cur = acc_q.pop_front();
                    else cur = '{fetch: 1'b0, addr: 32'h0, wdata: 32'h0, data: 32'h0, we: 1'b0,
                                 size: 3'b000, delay: 0, flush: -1};
                end
                check("mem_we", bus.mem_we, cur.we);
                check("mem_size", bus.mem_size, cur.size);
                check("mem_addr", bus.mem_addr, cur.addr);
                if (!cur.fetch) check("mem_wdata", bus.mem_wdata, cur.wdata);
                lim = (cur.delay >= TO) ? TO - 1 : cur.delay;
                check("mem_req within wait budget", idx <= lim, 1);
                bus.mem_ready = (idx == cur.delay);
                bus.mem_rdata = bus.mem_ready ? cur.data : $urandom;
                if (cur.fetch) begin
                    flush_F = (idx == cur.flush);
                    if (flush_F) begin
                        if_req = 1'b0; i_done = 1'b1; i_rel = 1'b0;
                    end
                end else begin
                    flush_F = 1'($urandom_range(0, 1));
                end
                idx++;
            end else begin
                in_acc        = 1'b0;
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom;
                flush_F       = 1'b0;
                if (i_done && d_done && d_started) break;
            end
        end

        if (t > 80) begin
            check("scenario finished in budget", t, 80);
            if_req = 1'b0; dm_req = 1'b0; flush_F = 1'b0; bus.mem_ready = 1'b1;
            repeat (TO + 4) @(posedge clk);
            #1 bus.mem_ready = 1'b0;
        end
        @(posedge clk); #1;
        check("accesses outstanding", acc_q.size(), 0);
        check("fetch completions outstanding", if_exp_q.size(), 0);
        check("data completions outstanding", dm_exp_q.size(), 0);
        acc_q.delete();
        if_exp_q.delete();
        dm_exp_q.delete();
    endtask

    task automatic reset_mid_store();
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_size = 3'b001;
        dm_addr = 32'h0000_0040; dm_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("store grant mem_req", bus.mem_req, 1);
        check("store mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("store mem_size", bus.mem_size, 3'b001);
        rst = 1'b0;
        #1;
        check("mem_req drops on async reset", bus.mem_req, 0);
        check("timeout_err cleared by reset", timeout_err, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; dm_req = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            check("no access after reset", bus.mem_req, 0);
            check("no dm_valid after reset", dm_valid, 0);
        end
    endtask

    initial begin
        scen_t s;
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0; flush_F = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_size = 3'b000; dm_addr = '0; dm_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Fetch only, ready after two wait cycles.
        s = rand_scen();
        s.do_i = 1'b1; s.do_d = 1'b0; s.i_addr = 32'h10; s.i_data = 32'h00A0_0513;
        s.i_delay = 2; s.i_flush = -1; s.d_offset = 0;
        run_scen(s);

        // Simultaneous fetch and word load: data first.
        s = rand_scen();
        s.do_i = 1'b1; s.do_d = 1'b1; s.d_addr = 32'h100; s.d_size = 3'b100; s.d_we = 1'b0;
        s.i_delay = 1; s.d_delay = 1; s.i_flush = -1; s.d_offset = 0;
        run_scen(s);

        // Flush in second wait cycle, ready in fourth.
        s = rand_scen();
        s.do_i = 1'b1; s.do_d = 1'b0; s.i_delay = 3; s.i_flush = 1; s.d_offset = 0;
        run_scen(s);

        // Data access that never gets ready.
        s = rand_scen();
        s.do_i = 1'b0; s.do_d = 1'b1; s.d_we = 1'b0; s.d_delay = 99; s.d_offset = 0;
        run_scen(s);

        for (int n = 0; n < 200; n++) run_scen(rand_scen());

        reset_mid_store();

        for (int n = 0; n < 20; n++) run_scen(rand_scen());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
